// File: rtl/cla_serial_adder_if.sv
// Handshake and data bundle for cla_serial_adder.
//
// Handshake rule (both directions): a transfer happens on a rising clock edge
// where valid and ready are both high. The producer holds its payload stable
// while valid is high and ready is low; the consumer may change ready freely.
//
//   in_valid/in_ready    : operand transfer, payload a, b, cin
//   out_valid/out_ready  : result transfer, payload sum, cout, ovf
//   busy                 : high while nibbles are being added
//   dbg_state            : current FSM state code, for observation only
//
// The master modport is the side that drives operands and consumes results.
// The slave modport is the adder itself.
interface cla_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic [1:0]       dbg_state;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy, dbg_state
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy, dbg_state
  );
endinterface

// File: rtl/cla_serial_adder.sv
// Multi-cycle WIDTH-bit adder built around one 4-bit carry-lookahead slice.
// Operands are latched on accept, then one nibble per cycle (LSB first) is
// pushed through the slice. The slice carry-out is registered and becomes the
// next nibble's carry-in, so there is no combinational path from the inputs
// to any output.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    cla_serial_adder_if.slave: in_valid/in_ready, a, b, cin,
//          out_valid/out_ready, sum, cout, ovf, busy, dbg_state
module cla_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cla_serial_adder_if.slave    bus
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_width_check
    $error("cla_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ovf_reg;

  // Bit offset of the current nibble.
  logic [IW+1:0]    base;
  logic [3:0]       an;
  logic [3:0]       bn;
  logic [3:0]       p;
  logic [3:0]       g;
  logic [4:0]       c;   // c[0] = carry in, c[4] = slice carry out

  assign base = {idx, 2'b00};
  assign an   = a_reg[base +: 4];
  assign bn   = b_reg[base +: 4];
  assign p    = an ^ bn;
  assign g    = an & bn;

  // Flattened lookahead: every group carry depends only on p, g and c[0].
  assign c[0] = carry_reg;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (&p & c[0]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid)           state_nxt = BUSY;
      BUSY: if (idx == LAST)            state_nxt = DONE;
      DONE: if (bus.out_ready)          state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            carry_reg <= bus.cin;
            idx       <= '0;
            sum_reg   <= '0;
          end
        end
        BUSY: begin
          sum_reg[base +: 4] <= p ^ c[3:0];
          carry_reg          <= c[4];
          if (idx == LAST) begin
            // Last nibble: c[3] is the carry into the MSB of the word.
            cout_reg <= c[4];
            ovf_reg  <= c[3] ^ c[4];
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;  // DONE holds the result until the next accept
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == BUSY);
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.dbg_state = state;

endmodule

// File: doc/cla_serial_adder.md
Name: cla_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder built around a single 4-bit carry-lookahead slice. The slice computes p=a^b, g=a&b and the group carries c[0..3] and cout.
- Each cycle the block feeds one 4-bit nibble of the latched operands into the slice, starting at the LSB. It registers the slice carry-out as the next cycle's carry-in and assembles the sum nibble by nibble.
- Sits in the datapath wherever a wide add is needed at low area. It has a valid/ready handshake on both sides.

Parameters:
- WIDTH, 16, operand/sum width in bits. Must be a multiple of 4 and at least 4. Other values are a synthesis error.
- NIB, WIDTH/4, number of nibble slices (derived, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered sum, equal to (a+b+cin) mod 2^WIDTH
- cout  output  1  carry out of the MSB
- ovf  output  1  two's-complement overflow: carry into the MSB XOR cout
- busy  output  1  high in BUSY state

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; internal a/b/carry/index registers clear to 0.
  - sum=0, cout=0, ovf=0, out_valid=0, busy=0.
  - in_ready=1 once rst_n deasserts.
- FSM states are IDLE, BUSY and DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE). busy = (state==BUSY).
- IDLE:
  - On the edge where in_valid&in_ready: latch a, b; carry_reg=cin; idx=0; clear sum; go to BUSY.
  - a/b/cin are ignored at all other times.
- BUSY, one nibble per cycle:
  - Slice inputs: a_reg[4*idx+:4], b_reg[4*idx+:4], carry_reg.
  - At each edge: sum[4*idx+:4] <= p ^ c; carry_reg <= slice cout; idx <= idx+1.
  - When idx==NIB-1 at the edge:
    - cout <= slice cout;
    - ovf <= slice c[3] XOR slice cout;
    - go to DONE.
- DONE:
  - sum/cout/ovf are held stable while out_ready=0.
  - On the edge where out_valid&out_ready: go to IDLE. sum/cout/ovf keep their values until the next accept.
- Latency:
  - The accept edge is edge 0. out_valid rises after edge NIB (WIDTH=16: 4 edges).
  - WIDTH=4: BUSY lasts exactly one cycle.
- Throughput: one operation per NIB+2 cycles minimum. No overlap: in_ready stays 0 in BUSY and DONE, so a new request waits.
- Carry chain: the inter-nibble carry is registered only. There is no combinational path from cin or a/b to any output.
- idx is ceil(log2(NIB)) bits wide, minimum 1, and never wraps past NIB-1.
- Reset mid-operation (BUSY or DONE): everything clears immediately, the partial result is discarded, and no out_valid pulse is produced.
- in_valid held high while the block is busy is not queued; it is sampled only in IDLE.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1 -> sum=0x5555, cout=0, ovf=0. out_valid rises 4 cycles after the accept edge and stays high 1 cycle.
- a=0xFFFF, b=0x0001, cin=0 (carry ripples through every nibble) -> sum=0x0000, cout=1, ovf=0. Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - Required: sum/cout/ovf stable, in_ready=0.
  - A new in_valid with a=0x0001 is ignored.
  - When out_ready=1: return to IDLE; the next operation is accepted one cycle later.
- Reset in BUSY: assert rst_n=0 after 2 nibbles -> out_valid=0, sum=0, busy=0 immediately. After release, in_ready=1, and a fresh 0x00FF+0x0001 gives 0x0100.
- WIDTH=4 instance: a=0x9, b=0x8, cin=1 -> sum=0x2, cout=1, ovf=1, with out_valid 1 cycle after accept. Follow with 1000 random operands checked against a+b+cin, including back-to-back requests.
